lzc_seq_norm: RTL and testbench

LZC_SEQ_NORM -- requirements
Module: lzc_seq_norm

---
 rtl/lzc_seq_norm.sv | 174 +++++++++++++++++
 tb/tb_lzc_seq_norm.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_seq_norm.sv
// Sequential leading/trailing zero counter with normalising shift, scanning CHUNK_W bits per cycle.
// Define LZC_SEQ_EARLY_EXIT_EN to leave the scan at the first nonzero chunk instead of always scanning every chunk.
module lzc_seq_norm #(
  parameter int WIDTH     = 64,
  parameter int CHUNK_W   = 8,
  parameter bit MODE      = 1'b1,
  parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 start_valid_i,
  output logic                 start_ready_o,
  input  logic [WIDTH-1:0]     op_i,
  output logic                 finish_valid_o,
  input  logic                 finish_ready_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o,
  output logic [WIDTH-1:0]     norm_o
);

  localparam int N     = (WIDTH + CHUNK_W - 1) / CHUNK_W;
  localparam int PW    = N * CHUNK_W;
  localparam int PAD   = PW - WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef LZC_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0]     r_op;
  logic [IDX_W-1:0]     r_chunkIdx;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_hit;
  logic [CNT_WIDTH-1:0] r_cntOut;
  logic                 r_emptyOut;
  logic [WIDTH-1:0]     r_normOut;

  logic [PW-1:0]        w_padded;
  logic [PW-1:0]        w_aligned;
  logic [CHUNK_W-1:0]   w_chunk;
  logic [CHUNK_W-1:0]   w_chunkOrd;
  logic [CNT_WIDTH-1:0] w_inLz;
  logic                 w_found;
  logic                 w_chunkNz;
  logic [CNT_WIDTH-1:0] w_hitCnt;
  logic                 w_lastChunk;
  logic                 w_scanDone;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_normShift;

  // The current chunk is brought to a fixed slice, reordered so its first-examined bit is the MSB.
  always_comb begin
    w_padded   = '0;
    w_aligned  = '0;
    w_chunk    = '0;
    w_chunkOrd = '0;
    if (MODE) begin
      w_padded   = PW'(r_op) << PAD;
      w_aligned  = w_padded << (int'(r_chunkIdx) * CHUNK_W);
      w_chunk    = w_aligned[PW-1 -: CHUNK_W];
      w_chunkOrd = w_chunk;
    end else begin
      w_padded   = PW'(r_op);
      w_aligned  = w_padded >> (int'(r_chunkIdx) * CHUNK_W);
      w_chunk    = w_aligned[CHUNK_W-1:0];
      for (int i = 0; i < CHUNK_W; i++) begin
        w_chunkOrd[i] = w_chunk[CHUNK_W-1-i];
      end
    end
  end

  always_comb begin
    w_inLz  = CNT_WIDTH'(CHUNK_W);
    w_found = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      if (!w_found && w_chunkOrd[CHUNK_W-1-i]) begin
        w_inLz  = CNT_WIDTH'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_chunkNz      = |w_chunk;
  assign w_hitCnt       = CNT_WIDTH'(int'(r_chunkIdx) * CHUNK_W) + w_inLz;
  assign w_lastChunk    = (r_chunkIdx == IDX_W'(N - 1));
  assign w_scanDone     = w_lastChunk || (EARLY_EXIT && w_chunkNz);
  assign start_ready_o  = rst_n && (r_state == IDLE);
  assign w_accept       = start_valid_i && start_ready_o && !flush_i;
  assign finish_valid_o = (r_state == DONE);
  assign w_normShift    = MODE ? (r_op << r_cnt) : (r_op >> r_cnt);

  assign cnt_o   = r_cntOut;
  assign empty_o = r_emptyOut;
  assign norm_o  = r_normOut;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush wins over any handshake that happens in the same cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start_valid_i) w_nextState = SCAN;
      SCAN:    if (w_scanDone) w_nextState = SHIFT;
      SHIFT:   w_nextState = DONE;
      DONE:    if (finish_ready_i) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush_i) begin
      w_nextState = IDLE;
    end
  end

  // Only the first nonzero chunk sets the count; outputs change solely on the SHIFT edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_chunkIdx <= '0;
      r_cnt      <= '0;
      r_hit      <= 1'b0;
      r_cntOut   <= '0;
      r_emptyOut <= 1'b0;
      r_normOut  <= '0;
    end else if (!flush_i) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= op_i;
            r_chunkIdx <= '0;
            r_cnt      <= '0;
            r_hit      <= 1'b0;
          end
        end
        SCAN: begin
          if (!r_hit && w_chunkNz) begin
            r_hit <= 1'b1;
            r_cnt <= w_hitCnt;
          end else if (!r_hit && w_scanDone) begin
            r_cnt <= CNT_WIDTH'(WIDTH);
          end
          if (!w_scanDone) begin
            r_chunkIdx <= r_chunkIdx + IDX_W'(1);
          end
        end
        SHIFT: begin
          r_cntOut   <= r_cnt;
          r_emptyOut <= !r_hit;
          r_normOut  <= r_hit ? w_normShift : '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_seq_norm.sv
// Self-checking bench: one MODE=1 and one MODE=0 instance share stimulus and are compared against a bit-level zero-count model.
// Expected latency follows LZC_SEQ_EARLY_EXIT_EN when it is defined for the build.
module tb_lzc_seq_norm;

  localparam int WIDTH     = 64;
  localparam int CHUNK_W   = 8;
  localparam int CNT_WIDTH = 7;
  localparam int NCHUNK    = 8;

`ifdef LZC_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rstN;
  logic                 flush;
  logic                 startValid;
  logic [WIDTH-1:0]     opIn;
  logic                 finishReady;

  logic                 srdy1, fv1, empty1;
  logic [CNT_WIDTH-1:0] cnt1;
  logic [WIDTH-1:0]     norm1;
  logic                 srdy0, fv0, empty0;
  logic [CNT_WIDTH-1:0] cnt0;
  logic [WIDTH-1:0]     norm0;

  int nChecks = 0;
  int nPass   = 0;

  lzc_seq_norm #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W), .MODE(1'b1)) dutLead (
    .clk(clk), .rst_n(rstN), .flush_i(flush),
    .start_valid_i(startValid), .start_ready_o(srdy1), .op_i(opIn),
    .finish_valid_o(fv1), .finish_ready_i(finishReady),
    .cnt_o(cnt1), .empty_o(empty1), .norm_o(norm1)
  );

  lzc_seq_norm #(.WIDTH(WIDTH), .CHUNK_W(CHUNK_W), .MODE(1'b0)) dutTrail (
    .clk(clk), .rst_n(rstN), .flush_i(flush),
    .start_valid_i(startValid), .start_ready_o(srdy0), .op_i(opIn),
    .finish_valid_o(fv0), .finish_ready_i(finishReady),
    .cnt_o(cnt0), .empty_o(empty0), .norm_o(norm0)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Absolute safety net so the run can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Bit-by-bit reference: the count is the distance of the first set bit from the scan start.
  function automatic void refModel(input logic [63:0] op, input bit mode,
                                   output logic [6:0] cnt, output logic empty,
                                   output logic [63:0] norm, output int lat);
    int c;
    int pos;
    c = WIDTH;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      pos = mode ? (WIDTH - 1 - i) : i;
      if (op[pos]) c = i;
    end
    empty = (c == WIDTH);
    cnt   = 7'(c);
    norm  = empty ? 64'd0 : (mode ? (op << c) : (op >> c));
    lat   = (EARLY && !empty) ? (c / CHUNK_W + 2) : (NCHUNK + 1);
  endfunction

  // One transaction on both instances with finish_ready held high; latency is counted in edges after accept.
  task automatic applyStimulus(input logic [63:0] op);
    int lat1, lat0, eLat;
    logic [6:0]  gCnt1, gCnt0, eCnt;
    logic        gEmp1, gEmp0, eEmp;
    logic [63:0] gNorm1, gNorm0, eNorm;
    @(negedge clk);
    checkOutput("startReadyLead", srdy1, 1);
    checkOutput("startReadyTrail", srdy0, 1);
    startValid = 1'b1;
    opIn       = op;
    @(posedge clk);
    #1 startValid = 1'b0;
    lat1 = -1; lat0 = -1;
    gCnt1 = '0; gCnt0 = '0; gEmp1 = 0; gEmp0 = 0; gNorm1 = '0; gNorm0 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (lat1 < 0 && fv1) begin
        lat1 = k; gCnt1 = cnt1; gEmp1 = empty1; gNorm1 = norm1;
      end
      if (lat0 < 0 && fv0) begin
        lat0 = k; gCnt0 = cnt0; gEmp0 = empty0; gNorm0 = norm0;
      end
    end
    refModel(op, 1'b1, eCnt, eEmp, eNorm, eLat);
    checkOutput("latLead", 64'(lat1), 64'(eLat));
    checkOutput("cntLead", gCnt1, eCnt);
    checkOutput("emptyLead", gEmp1, eEmp);
    checkOutput("normLead", gNorm1, eNorm);
    refModel(op, 1'b0, eCnt, eEmp, eNorm, eLat);
    checkOutput("latTrail", 64'(lat0), 64'(eLat));
    checkOutput("cntTrail", gCnt0, eCnt);
    checkOutput("emptyTrail", gEmp0, eEmp);
    checkOutput("normTrail", gNorm0, eNorm);
  endtask

  // Result held in DONE while finish_ready is low, then released by the handshake.
  task automatic stallTest(input logic [63:0] op);
    int waited;
    int eLat1, eLat0;
    logic [6:0]  eCnt1, eCnt0;
    logic        eEmp1, eEmp0;
    logic [63:0] eNorm1, eNorm0;
    refModel(op, 1'b1, eCnt1, eEmp1, eNorm1, eLat1);
    refModel(op, 1'b0, eCnt0, eEmp0, eNorm0, eLat0);
    finishReady = 1'b0;
    @(negedge clk);
    startValid = 1'b1;
    opIn       = op;
    @(posedge clk);
    #1 startValid = 1'b0;
    waited = 0;
    while (!(fv1 && fv0) && waited < 20) begin
      @(posedge clk);
      #1 waited++;
    end
    checkOutput("stallBothValid", 64'(fv1 && fv0), 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stallValidLead", fv1, 1);
      checkOutput("stallReadyLead", srdy1, 0);
      checkOutput("stallReadyTrail", srdy0, 0);
      checkOutput("stallCntLead", cnt1, eCnt1);
      checkOutput("stallNormLead", norm1, eNorm1);
      checkOutput("stallCntTrail", cnt0, eCnt0);
      checkOutput("stallNormTrail", norm0, eNorm0);
    end
    finishReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("releaseValidLead", fv1, 0);
    checkOutput("releaseReadyLead", srdy1, 1);
    checkOutput("releaseValidTrail", fv0, 0);
    checkOutput("releaseReadyTrail", srdy0, 1);
    checkOutput("heldCntLead", cnt1, eCnt1);
    checkOutput("heldNormTrail", norm0, eNorm0);
  endtask

  // Abort during the second scan cycle; no result may appear afterwards.
  task automatic flushTest();
    int seen;
    @(negedge clk);
    startValid = 1'b1;
    opIn       = 64'd0;
    @(posedge clk);
    #1 startValid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flushReadyLead", srdy1, 1);
    checkOutput("flushReadyTrail", srdy0, 1);
    checkOutput("flushValidLead", fv1, 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 if (fv1 || fv0) seen++;
    end
    checkOutput("flushNoResult", 64'(seen), 0);
  endtask

  // Reset asserted while both instances sit in SHIFT on an all-zero operand.
  task automatic resetInShiftTest();
    int seen;
    @(negedge clk);
    startValid = 1'b1;
    opIn       = 64'd0;
    @(posedge clk);
    #1 startValid = 1'b0;
    repeat (NCHUNK) @(posedge clk);
    #1 rstN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstShiftCntLead", cnt1, 0);
    checkOutput("rstShiftEmptyLead", empty1, 0);
    checkOutput("rstShiftNormLead", norm1, 0);
    checkOutput("rstShiftValidLead", fv1, 0);
    checkOutput("rstShiftReadyLead", srdy1, 0);
    checkOutput("rstShiftCntTrail", cnt0, 0);
    checkOutput("rstShiftNormTrail", norm0, 0);
    checkOutput("rstShiftReadyTrail", srdy0, 0);
    rstN = 1'b1;
    #1;
    checkOutput("rstReleaseReady", srdy1, 1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 if (fv1 || fv0) seen++;
    end
    checkOutput("rstNoResult", 64'(seen), 0);
  endtask

  initial begin
    logic [63:0] r;
    int sh;
    rstN        = 1'b0;
    flush       = 1'b0;
    startValid  = 1'b0;
    opIn        = '0;
    finishReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReadyLead", srdy1, 0);
    checkOutput("resetValidLead", fv1, 0);
    checkOutput("resetCntLead", cnt1, 0);
    checkOutput("resetEmptyLead", empty1, 0);
    checkOutput("resetNormLead", norm1, 0);
    checkOutput("resetCntTrail", cnt0, 0);
    checkOutput("resetNormTrail", norm0, 0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("releaseReadyLead", srdy1, 1);
    checkOutput("releaseReadyTrail", srdy0, 1);

    applyStimulus(64'h0000_0100_0000_0000);
    applyStimulus(64'h0);
    applyStimulus(64'h8000_0000_0000_0000);
    applyStimulus(64'h10);
    applyStimulus(64'h1_0000_0000);
    applyStimulus(64'h1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF);

    stallTest(64'h0000_0000_0040_0000);
    flushTest();
    applyStimulus(64'h0000_2000_0000_0800);
    applyStimulus(64'h0000_0100_0000_0000);
    resetInShiftTest();
    applyStimulus(64'h0000_0000_0300_0000);

    for (int t = 0; t < 24; t++) begin
      r  = {$urandom, $urandom};
      sh = $urandom_range(0, 64);
      if ($urandom_range(0, 1) == 1) r = r >> sh;
      else r = r << sh;
      applyStimulus(r);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
